// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock circular-buffer FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_W = 4;
    localparam int FIFO_DEPTH  = 8;

    // Number of address bits needed to index a buffer of the given depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, registered read port.
// Only the read register is reset; the storage array keeps its contents.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = ptr_width(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; no reset so the array maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register: cleared by reset, otherwise loads only on an accepted read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with wrapping pointers and an occupancy counter.
// Optional error pulses (overflow/underflow) are built when FIFO_ERR_FLAGS_EN
// is defined; the default build exposes only the eight base ports.
module fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int ADDR_W = ptr_width(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_wr;
    logic              do_rd;

    // Flags come straight from the counter; acceptance is gated by them so
    // overflow/underflow requests never disturb state.
    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        do_wr = wr_en && !full;
        do_rd = rd_en && !empty;
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (do_rd),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

`ifdef FIFO_ERR_FLAGS_EN
    // One-cycle error pulses flagging requests that were refused.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end
`endif

endmodule : fifo

// File: tb/tb_fifo.sv
// Directed testbench for fifo (default DATA_W=4, DEPTH=8).
module tb_fifo;

    logic [3:0] data_out;
    logic       empty;
    logic       full;
    logic [3:0] data_in;
    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int tests = 0;
    int fails = 0;

    fifo dut (
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .data_in  (data_in),
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] d);
        data_in = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [3:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk(tag, {4'd0, data_out}, {4'd0, exp});
    endtask

    logic [3:0] wrap_vals [7];

    initial begin
        wrap_vals = '{4'd5, 4'd11, 4'd14, 4'd1, 4'd6, 4'd9, 4'd3};
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

        // Reset
        tick();
        chk("rst_empty", {7'd0, empty}, 8'd1);
        chk("rst_full", {7'd0, full}, 8'd0);
        chk("rst_dout", {4'd0, data_out}, 8'd0);
        rst = 1'b1;
        tick(); tick(); tick();
        chk("idle_empty", {7'd0, empty}, 8'd1);
        chk("idle_full", {7'd0, full}, 8'd0);
        chk("idle_dout", {4'd0, data_out}, 8'd0);

        // Fill 1..8
        for (int i = 1; i <= 8; i++) begin
            push(4'(i));
            if (i == 1) chk("fill1_empty", {7'd0, empty}, 8'd0);
            if (i == 7) chk("fill7_full", {7'd0, full}, 8'd0);
        end
        chk("fill8_full", {7'd0, full}, 8'd1);
        chk("fill8_empty", {7'd0, empty}, 8'd0);

        // Overflow: write of 15 must be dropped
        push(4'd15);
        chk("ovf_full", {7'd0, full}, 8'd1);
        chk("ovf_dout", {4'd0, data_out}, 8'd0);

        // Drain 1..8
        for (int i = 1; i <= 8; i++) begin
            pop_chk("drain_dout", 4'(i));
            if (i == 1) chk("drain1_full", {7'd0, full}, 8'd0);
            if (i == 7) chk("drain7_empty", {7'd0, empty}, 8'd0);
        end
        chk("drain8_empty", {7'd0, empty}, 8'd1);

        // Underflow: data_out holds 8
        pop_chk("udf_dout", 4'd8);
        chk("udf_empty", {7'd0, empty}, 8'd1);

        // Wrap-around
        push(4'd4); push(4'd7); push(4'd2);
        pop_chk("wrap_pre0", 4'd4);
        pop_chk("wrap_pre1", 4'd7);
        pop_chk("wrap_pre2", 4'd2);
        for (int i = 0; i < 7; i++) push(wrap_vals[i]);
        chk("wrap_full", {7'd0, full}, 8'd0);
        chk("wrap_empty", {7'd0, empty}, 8'd0);
        for (int i = 0; i < 7; i++) pop_chk("wrap_dout", wrap_vals[i]);
        chk("wrap_end_empty", {7'd0, empty}, 8'd1);

        // Simultaneous read/write with 3 entries
        push(4'd4); push(4'd7); push(4'd2);
        data_in = 4'd5; wr_en = 1'b1; rd_en = 1'b1;
        tick(); chk("sim_dout0", {4'd0, data_out}, 8'd4);
        tick(); chk("sim_dout1", {4'd0, data_out}, 8'd7);
        tick(); chk("sim_dout2", {4'd0, data_out}, 8'd2);
        tick(); chk("sim_dout3", {4'd0, data_out}, 8'd5);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("sim_empty", {7'd0, empty}, 8'd0);
        chk("sim_full", {7'd0, full}, 8'd0);
        pop_chk("sim_rem0", 4'd5);
        pop_chk("sim_rem1", 4'd5);
        pop_chk("sim_rem2", 4'd5);
        chk("sim_end_empty", {7'd0, empty}, 8'd1);

        // Simultaneous while empty: write only, no read-through
        data_in = 4'd9; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("simE_dout", {4'd0, data_out}, 8'd5);
        chk("simE_empty", {7'd0, empty}, 8'd0);

        // Simultaneous while full: read only, write of 12 dropped
        for (int i = 1; i <= 7; i++) push(4'(i));
        chk("simF_full_pre", {7'd0, full}, 8'd1);
        data_in = 4'd12; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("simF_dout", {4'd0, data_out}, 8'd9);
        chk("simF_full", {7'd0, full}, 8'd0);
        for (int i = 1; i <= 7; i++) pop_chk("simF_rest", 4'(i));
        chk("simF_end_empty", {7'd0, empty}, 8'd1);

        // Mid-operation reset with 5 entries
        for (int i = 1; i <= 5; i++) push(4'(i + 8));
        chk("mid_pre_empty", {7'd0, empty}, 8'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_empty", {7'd0, empty}, 8'd1);
        chk("mid_full", {7'd0, full}, 8'd0);
        chk("mid_dout", {4'd0, data_out}, 8'd0);
        pop_chk("mid_rd_ignored", 4'd0);
        chk("mid_rd_empty", {7'd0, empty}, 8'd1);

        // Normal operation after reset
        push(4'd6);
        pop_chk("post_rst_dout", 4'd6);
        chk("post_rst_empty", {7'd0, empty}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo
